// File: rtl/hit_memory_retriever_pkg.sv
// Shared widths, FSM encoding and HCM field helpers for the hit retrieval path.
package hit_memory_retriever_pkg;

  localparam int unsigned SSIDBITS         = 13;
  localparam int unsigned COLINDEXBITS_HNM = 5;
  localparam int unsigned ROWINDEXBITS_HIM = 9;
  localparam int unsigned MAXHITNBITS      = 4;
  localparam int unsigned HITINFOBITS      = 8;
  localparam int unsigned HITSPERROW       = 3;

  localparam int unsigned NCOLS_HNM   = 2 ** COLINDEXBITS_HNM;
  localparam int unsigned NCOLS_HCM   = ROWINDEXBITS_HIM + MAXHITNBITS;
  localparam int unsigned NCOLS_HIM   = HITSPERROW * HITINFOBITS;
  localparam int unsigned ROWBITS_HNM = SSIDBITS - COLINDEXBITS_HNM;
  localparam int unsigned SLOTBITS    = (HITSPERROW > 1) ? $clog2(HITSPERROW) : 1;

  // Slot capacity expressed in the count field's width for direct comparison.
  localparam logic [MAXHITNBITS-1:0] HITSPERROW_CNT = MAXHITNBITS'(HITSPERROW);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_HNM = 3'd1,
    S_WAIT_HCM = 3'd2,
    S_WAIT_HIM = 3'd3,
    S_STREAM   = 3'd4
  } retriever_state_e;

  // HCM word layout: {HIM base address, hit count}.
  function automatic logic [MAXHITNBITS-1:0] hcm_count(input logic [NCOLS_HCM-1:0] w);
    return w[MAXHITNBITS-1:0];
  endfunction

  function automatic logic [ROWINDEXBITS_HIM-1:0] hcm_addr(input logic [NCOLS_HCM-1:0] w);
    return w[NCOLS_HCM-1 -: ROWINDEXBITS_HIM];
  endfunction

  function automatic logic [NCOLS_HCM-1:0] hcm_pack(input logic [ROWINDEXBITS_HIM-1:0] addr,
                                                     input logic [MAXHITNBITS-1:0]      cnt);
    return {addr, cnt};
  endfunction

endpackage

// File: rtl/hit_memory_retriever_mem_read_waiter.sv
// Block-memory read latency timer: start loads RD_LAT-1, done is high in the
// cycle whose closing edge may sample the read data.
module mem_read_waiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int unsigned   CW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(RD_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  // Next counter value: reload on start, count down while armed, disarm at zero.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      cnt_d    = LOAD;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Counter and armed-flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (cnt_q == '0);

endmodule

// File: rtl/hit_memory_retriever.sv
// Answers one SSID query at a time by walking HNM -> HCM -> HIM and streaming
// the stored hit-info words out oldest first.
module hit_memory_retriever
  import hit_memory_retriever_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        storageBusy,
  input  logic                        queryValid,
  input  logic [SSIDBITS-1:0]         querySSID,
  output logic                        queryReady,
  output logic [ROWBITS_HNM-1:0]      rowIndex_HNM,
  input  logic [NCOLS_HNM-1:0]        dataOutput_HNM,
  output logic [SSIDBITS-1:0]         rowIndex_HCM,
  input  logic [NCOLS_HCM-1:0]        dataOutput_HCM,
  output logic [ROWINDEXBITS_HIM-1:0] rowIndex_HIM,
  input  logic [NCOLS_HIM-1:0]        dataOutput_HIM,
  output logic                        hitValid,
  input  logic                        hitReady,
  output logic [HITINFOBITS-1:0]      hitInfo,
  output logic                        hitLast,
  output logic [MAXHITNBITS-1:0]      hitCount,
  output logic                        overflow,
  output logic                        emptyDone
);

  retriever_state_e            state_q, state_d;
  logic [SSIDBITS-1:0]         ssid_q, ssid_d;
  logic [ROWBITS_HNM-1:0]      row_hnm_q, row_hnm_d;
  logic [SSIDBITS-1:0]         row_hcm_q, row_hcm_d;
  logic [ROWINDEXBITS_HIM-1:0] row_him_q, row_him_d;
  logic [NCOLS_HIM-1:0]        him_row_q, him_row_d;
  logic [SLOTBITS-1:0]         slot_q, slot_d;
  logic [MAXHITNBITS-1:0]      hit_count_q, hit_count_d;
  logic                        overflow_q, overflow_d;
  logic                        empty_done_q, empty_done_d;

  logic                        wait_start;
  logic                        wait_done;
  logic                        query_ready;
  logic [MAXHITNBITS-1:0]      hcm_cnt;
  logic [MAXHITNBITS-1:0]      n_hits;

  mem_read_waiter #(
    .RD_LAT (RD_LAT)
  ) u_waiter (
    .clock (clock),
    .reset (reset),
    .start (wait_start),
    .done  (wait_done)
  );

  assign query_ready = (state_q == S_IDLE) && !storageBusy && !reset;

  // Next-state, read-address and response bookkeeping for the lookup chain.
  always_comb begin
    state_d      = state_q;
    ssid_d       = ssid_q;
    row_hnm_d    = row_hnm_q;
    row_hcm_d    = row_hcm_q;
    row_him_d    = row_him_q;
    him_row_d    = him_row_q;
    slot_d       = slot_q;
    hit_count_d  = hit_count_q;
    overflow_d   = overflow_q;
    empty_done_d = 1'b0;
    wait_start   = 1'b0;
    hcm_cnt      = hcm_count(dataOutput_HCM);
    n_hits       = (hit_count_q > HITSPERROW_CNT) ? HITSPERROW_CNT : hit_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (queryValid && query_ready) begin
          ssid_d     = querySSID;
          row_hnm_d  = querySSID[SSIDBITS-1:COLINDEXBITS_HNM];
          wait_start = 1'b1;
          state_d    = S_WAIT_HNM;
        end
      end
      S_WAIT_HNM: begin
        if (wait_done) begin
          if (dataOutput_HNM[ssid_q[COLINDEXBITS_HNM-1:0]]) begin
            row_hcm_d  = ssid_q;
            wait_start = 1'b1;
            state_d    = S_WAIT_HCM;
          end else begin
            empty_done_d = 1'b1;
            hit_count_d  = '0;
            overflow_d   = 1'b0;
            state_d      = S_IDLE;
          end
        end
      end
      S_WAIT_HCM: begin
        if (wait_done) begin
          if (hcm_cnt == '0) begin
            empty_done_d = 1'b1;
            hit_count_d  = '0;
            overflow_d   = 1'b0;
            state_d      = S_IDLE;
          end else begin
            hit_count_d = hcm_cnt;
            overflow_d  = (hcm_cnt > HITSPERROW_CNT);
            row_him_d   = hcm_addr(dataOutput_HCM);
            wait_start  = 1'b1;
            state_d     = S_WAIT_HIM;
          end
        end
      end
      S_WAIT_HIM: begin
        if (wait_done) begin
          him_row_d = dataOutput_HIM;
          // Oldest stored hit sits in the highest occupied slot.
          slot_d    = SLOTBITS'(n_hits - 1'b1);
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (hitReady) begin
          if (slot_q == '0) begin
            state_d = S_IDLE;
          end else begin
            slot_d = slot_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ssid_q       <= '0;
      row_hnm_q    <= '0;
      row_hcm_q    <= '0;
      row_him_q    <= '0;
      him_row_q    <= '0;
      slot_q       <= '0;
      hit_count_q  <= '0;
      overflow_q   <= 1'b0;
      empty_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ssid_q       <= ssid_d;
      row_hnm_q    <= row_hnm_d;
      row_hcm_q    <= row_hcm_d;
      row_him_q    <= row_him_d;
      him_row_q    <= him_row_d;
      slot_q       <= slot_d;
      hit_count_q  <= hit_count_d;
      overflow_q   <= overflow_d;
      empty_done_q <= empty_done_d;
    end
  end

  assign queryReady   = query_ready;
  assign rowIndex_HNM = row_hnm_q;
  assign rowIndex_HCM = row_hcm_q;
  assign rowIndex_HIM = row_him_q;
  assign hitValid     = (state_q == S_STREAM);
  assign hitInfo      = him_row_q[int'(slot_q)*HITINFOBITS +: HITINFOBITS];
  assign hitLast      = (state_q == S_STREAM) && (slot_q == '0);
  assign hitCount     = hit_count_q;
  assign overflow     = overflow_q;
  assign emptyDone    = empty_done_q;

endmodule

// File: tb/tb_hit_memory_retriever.sv
// Directed bench for hit_memory_retriever with a per-cycle reference model.
module tb_hit_memory_retriever;
  import hit_memory_retriever_pkg::*;

  localparam int unsigned RD_LAT = 1;

  logic                        clock;
  logic                        reset;
  logic                        storageBusy;
  logic                        queryValid;
  logic [SSIDBITS-1:0]         querySSID;
  logic                        queryReady;
  logic [ROWBITS_HNM-1:0]      rowIndex_HNM;
  logic [NCOLS_HNM-1:0]        dataOutput_HNM;
  logic [SSIDBITS-1:0]         rowIndex_HCM;
  logic [NCOLS_HCM-1:0]        dataOutput_HCM;
  logic [ROWINDEXBITS_HIM-1:0] rowIndex_HIM;
  logic [NCOLS_HIM-1:0]        dataOutput_HIM;
  logic                        hitValid;
  logic                        hitReady;
  logic [HITINFOBITS-1:0]      hitInfo;
  logic                        hitLast;
  logic [MAXHITNBITS-1:0]      hitCount;
  logic                        overflow;
  logic                        emptyDone;

  // Memory contents, read with one cycle from registered address to sampling edge.
  logic [NCOLS_HNM-1:0] hnm_mem [0:255];
  logic [NCOLS_HCM-1:0] hcm_mem [0:8191];
  logic [NCOLS_HIM-1:0] him_mem [0:511];

  assign dataOutput_HNM = hnm_mem[rowIndex_HNM];
  assign dataOutput_HCM = hcm_mem[rowIndex_HCM];
  assign dataOutput_HIM = him_mem[rowIndex_HIM];

  hit_memory_retriever #(
    .RD_LAT (RD_LAT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .storageBusy    (storageBusy),
    .queryValid     (queryValid),
    .querySSID      (querySSID),
    .queryReady     (queryReady),
    .rowIndex_HNM   (rowIndex_HNM),
    .dataOutput_HNM (dataOutput_HNM),
    .rowIndex_HCM   (rowIndex_HCM),
    .dataOutput_HCM (dataOutput_HCM),
    .rowIndex_HIM   (rowIndex_HIM),
    .dataOutput_HIM (dataOutput_HIM),
    .hitValid       (hitValid),
    .hitReady       (hitReady),
    .hitInfo        (hitInfo),
    .hitLast        (hitLast),
    .hitCount       (hitCount),
    .overflow       (overflow),
    .emptyDone      (emptyDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a query is a timeline of memory lookups counted in edges
  // since acceptance, ending in either an empty pulse or a queue of beats.
  bit                          model_live = 1'b0;
  bit                          m_busy, m_stream, m_empty, m_ovf;
  int                          m_elapsed;
  logic [SSIDBITS-1:0]         m_ssid;
  logic [ROWBITS_HNM-1:0]      m_hnm_addr;
  logic [SSIDBITS-1:0]         m_hcm_addr;
  logic [ROWINDEXBITS_HIM-1:0] m_him_addr;
  logic [MAXHITNBITS-1:0]      m_count;
  logic [7:0]                  m_q [$];

  always @(posedge clock) begin
    logic [NCOLS_HCM-1:0] w;
    logic [NCOLS_HIM-1:0] row;
    int unsigned          c;
    int unsigned          n;
    if (reset) begin
      model_live = 1'b1;
      m_busy = 0; m_stream = 0; m_empty = 0; m_ovf = 0; m_elapsed = 0;
      m_ssid = '0; m_hnm_addr = '0; m_hcm_addr = '0; m_him_addr = '0; m_count = '0;
      m_q.delete();
    end else if (model_live) begin
      m_empty = 0;
      if (!m_busy) begin
        if (queryValid && !storageBusy) begin
          m_ssid     = querySSID;
          m_hnm_addr = querySSID[12:5];
          m_busy     = 1;
          m_elapsed  = 0;
        end
      end else if (m_stream) begin
        if (hitReady) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_stream = 0;
            m_busy   = 0;
          end
        end
      end else begin
        m_elapsed++;
        w = hcm_mem[m_ssid];
        c = int'(w[3:0]);
        if (m_elapsed == RD_LAT) begin
          if (hnm_mem[m_ssid[12:5]][m_ssid[4:0]]) begin
            m_hcm_addr = m_ssid;
          end else begin
            m_empty = 1; m_busy = 0; m_count = '0; m_ovf = 0;
          end
        end else if (m_elapsed == 2 * RD_LAT) begin
          if (c == 0) begin
            m_empty = 1; m_busy = 0; m_count = '0; m_ovf = 0;
          end else begin
            m_count    = w[3:0];
            m_ovf      = (c > 3);
            m_him_addr = w[12:4];
          end
        end else if (m_elapsed == 3 * RD_LAT) begin
          row = him_mem[m_him_addr];
          n   = (c > 3) ? 3 : c;
          for (int i = int'(n) - 1; i >= 0; i--) m_q.push_back(8'(row >> (8 * i)));
          m_stream = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (model_live) begin
      chk("queryReady", queryReady, !reset && !m_busy && !storageBusy);
      chk("hitValid", hitValid, m_stream);
      chk("emptyDone", emptyDone, m_empty);
      chk("hitCount", hitCount, m_count);
      chk("overflow", overflow, m_ovf);
      chk("rowIndex_HNM", rowIndex_HNM, m_hnm_addr);
      chk("rowIndex_HCM", rowIndex_HCM, m_hcm_addr);
      chk("rowIndex_HIM", rowIndex_HIM, m_him_addr);
      if (m_stream && m_q.size() > 0) begin
        chk("hitInfo", hitInfo, m_q[0]);
        chk("hitLast", hitLast, m_q.size() == 1);
      end
    end
  end

  logic [7:0] beats [$];
  bit         lasts [$];

  // Issues one query, consumes its response and returns the cycle (accept
  // cycle = 0) of the first beat or of the empty pulse.
  task automatic do_query(input logic [SSIDBITS-1:0] s, input int stall,
                          input logic [7:0] exp_first,
                          output int first_cyc, output int empty_cyc);
    int cyc;
    int stalled;
    bit done;
    beats.delete();
    lasts.delete();
    first_cyc = -1; empty_cyc = -1; cyc = 0; stalled = 0; done = 0;
    querySSID  = s;
    queryValid = 1'b1;
    hitReady   = 1'b0;
    while (!done && cyc < 60) begin
      @(posedge clock); #2;
      cyc++;
      queryValid = 1'b0;
      hitReady   = 1'b0;
      if (emptyDone) begin
        empty_cyc = cyc;
        done = 1;
      end else if (hitValid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stalled < stall) begin
          chk("stall_hold", hitInfo, exp_first);
          stalled++;
        end else begin
          hitReady = 1'b1;
          beats.push_back(hitInfo);
          lasts.push_back(hitLast);
          if (hitLast) done = 1;
        end
      end
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL query_timeout: ssid %0h got no response in %0d cycles", s, cyc);
    end
    @(posedge clock); #2;
    hitReady = 1'b0;
  endtask

  task automatic check_beats(input string tag, input int n,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({tag, "_nbeats"}, beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      chk($sformatf("%s_beat%0d", tag, i), beats[i], e[i]);
      chk($sformatf("%s_last%0d", tag, i), lasts[i], (i == n - 1));
    end
  endtask

  initial begin
    int  f, e, cyc;
    bit  seen;
    reset = 1'b1; storageBusy = 1'b0; queryValid = 1'b0; hitReady = 1'b0; querySSID = '0;
    for (int i = 0; i < 256; i++)  hnm_mem[i] = '0;
    for (int i = 0; i < 8192; i++) hcm_mem[i] = '0;
    for (int i = 0; i < 512; i++)  him_mem[i] = '0;
    hnm_mem[8'h05] = 32'h0000_0001;            // 0x00A3: bit 3 clear
    hnm_mem[8'h02] = 32'h0000_0004;            // 0x0042: bit 2 set
    hcm_mem[13'h0042] = {9'h011, 4'd2};
    him_mem[9'h011] = 24'h00BBAA;
    hnm_mem[8'h08] = 32'h0000_0080;            // 0x0107: bit 7 set
    hcm_mem[13'h0107] = {9'h0C0, 4'd5};
    him_mem[9'h0C0] = 24'h332211;
    hnm_mem[8'hFF] = 32'h8000_0000;            // 0x1FFF: bit 31 set
    hcm_mem[13'h1FFF] = {9'h1FF, 4'd3};
    him_mem[9'h1FF] = 24'hC3C2C1;
    hnm_mem[8'h00] = 32'h0000_0001;            // 0x0000: bit 0 set
    hcm_mem[13'h0000] = {9'h000, 4'd1};
    him_mem[9'h000] = 24'hEEDD5A;
    hnm_mem[8'h03] = 32'h0000_0001;            // 0x0060: bit set, count 0

    repeat (3) @(posedge clock);
    #2;
    chk("rst_ready", queryReady, 1'b0);
    chk("rst_valid", hitValid, 1'b0);
    chk("rst_count", hitCount, 4'd0);
    chk("rst_hnm_addr", rowIndex_HNM, 8'h00);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", queryReady, 1'b1);

    // Empty via HNM.
    do_query(13'h00A3, 0, 8'h00, f, e);
    chk("t1_hnm_addr", rowIndex_HNM, 8'h05);
    chk("t1_empty_cycle", e, 2);
    chk("t1_no_beats", f, -1);
    chk("t1_count", hitCount, 4'd0);

    // Two hits.
    do_query(13'h0042, 0, 8'hBB, f, e);
    chk("t2_first_cycle", f, 4);
    chk("t2_count", hitCount, 4'd2);
    chk("t2_ovf", overflow, 1'b0);
    check_beats("t2", 2, 8'hBB, 8'hAA, 8'h00);

    // Same query with the consumer stalling.
    do_query(13'h0042, 5, 8'hBB, f, e);
    chk("t3_first_cycle", f, 4);
    check_beats("t3", 2, 8'hBB, 8'hAA, 8'h00);

    // Overflowed count.
    do_query(13'h0107, 0, 8'h33, f, e);
    chk("t4_count", hitCount, 4'd5);
    chk("t4_ovf", overflow, 1'b1);
    check_beats("t4", 3, 8'h33, 8'h22, 8'h11);

    // Exactly full row, highest SSID.
    do_query(13'h1FFF, 0, 8'hC3, f, e);
    chk("full_count", hitCount, 4'd3);
    chk("full_ovf", overflow, 1'b0);
    chk("full_him_addr", rowIndex_HIM, 9'h1FF);
    check_beats("full", 3, 8'hC3, 8'hC2, 8'hC1);

    // Single hit, SSID zero.
    do_query(13'h0000, 0, 8'h5A, f, e);
    chk("one_count", hitCount, 4'd1);
    check_beats("one", 1, 8'h5A, 8'h00, 8'h00);

    // Corrupt HCM entry with zero count.
    do_query(13'h0060, 0, 8'h00, f, e);
    chk("corrupt_empty_cycle", e, 3);
    chk("corrupt_count", hitCount, 4'd0);

    // Storage busy blocks acceptance.
    storageBusy = 1'b1; querySSID = 13'h0042; queryValid = 1'b1;
    repeat (3) begin
      @(posedge clock); #2;
      chk("t5_ready", queryReady, 1'b0);
      chk("t5_hnm_addr", rowIndex_HNM, 8'h03);
    end
    storageBusy = 1'b0;
    do_query(13'h0042, 0, 8'hBB, f, e);
    chk("t5_first_cycle", f, 4);
    check_beats("t5", 2, 8'hBB, 8'hAA, 8'h00);

    // Reset in the middle of a stream.
    querySSID = 13'h0107; queryValid = 1'b1; hitReady = 1'b0; cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clock); #2;
      cyc++;
      queryValid = 1'b0;
      if (hitValid) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL t6_timeout: no beat within %0d cycles", cyc);
    end
    chk("t6_first", hitInfo, 8'h33);
    hitReady = 1'b1;
    @(posedge clock); #2;
    hitReady = 1'b0;
    chk("t6_second", hitInfo, 8'h22);
    chk("t6_second_last", hitLast, 1'b0);
    reset = 1'b1;
    @(posedge clock); #2;
    chk("t6_abort_valid", hitValid, 1'b0);
    chk("t6_abort_last", hitLast, 1'b0);
    chk("t6_abort_count", hitCount, 4'd0);
    chk("t6_abort_ovf", overflow, 1'b0);
    chk("t6_abort_ready", queryReady, 1'b0);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("t6_ready", queryReady, 1'b1);
    do_query(13'h0042, 0, 8'hBB, f, e);
    chk("t6_fresh_first_cycle", f, 4);
    check_beats("t6_fresh", 2, 8'hBB, 8'hAA, 8'h00);

    repeat (2) @(posedge clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_memory_retriever.md
Name: hit_memory_retriever

Overview:
- Downstream consumer of the SSID hit-storage stage. Answers "which hits landed on SSID X?" after storage has filled the three block memories.
- The three memories are HNM (hits-new bitmap), HCM (hit count plus HIM base address) and HIM (packed hit info).
- Accepts one SSID query at a time and walks the chain HNM, then HCM, then HIM through dedicated read-only ports.
- Streams the stored hit-info words out one per accepted beat, flagging the last word and any truncation.

Parameters:
SSIDBITS, 13, width of an SSID
COLINDEXBITS_HNM, 5, SSID low bits selecting a bit within an HNM row (NCOLS_HNM = 2**COLINDEXBITS_HNM)
ROWINDEXBITS_HIM, 9, HIM address width; upper field of each HCM word
MAXHITNBITS, 4, hit-count field width; lower field of each HCM word
HITINFOBITS, 8, width of one hit-info word
HITSPERROW, 3, hit-info slots packed in one HIM row (NCOLS_HIM = HITSPERROW*HITINFOBITS)
RD_LAT, 1, block-memory read latency in cycles (address to dout), same for all three memories

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
storageBusy  in  1  high while storage is writing or clearing; new queries are not accepted
queryValid  in  1  query request
querySSID  in  SSIDBITS  SSID to look up
queryReady  out  1  high only in IDLE with storageBusy low
rowIndex_HNM  out  SSIDBITS-COLINDEXBITS_HNM  HNM read address
dataOutput_HNM  in  NCOLS_HNM  HNM read data
rowIndex_HCM  out  SSIDBITS  HCM read address
dataOutput_HCM  in  ROWINDEXBITS_HIM+MAXHITNBITS  HCM read data, {HIM address, count}
rowIndex_HIM  out  ROWINDEXBITS_HIM  HIM read address
dataOutput_HIM  in  NCOLS_HIM  HIM read data
hitValid  out  1  hit-info beat valid
hitReady  in  1  consumer accepts beat
hitInfo  out  HITINFOBITS  hit-info word
hitLast  out  1  final beat of this query
hitCount  out  MAXHITNBITS  stored count for the query; held stable for the whole response
overflow  out  1  count exceeded HITSPERROW, so earlier hits are lost; held with hitCount
emptyDone  out  1  one-cycle pulse: SSID had no hits, no beats follow

Behaviour:
- Reset values:
  - queryReady=0 during reset, 1 on the first cycle after reset if storageBusy=0.
  - hitValid, hitLast, emptyDone, overflow = 0; hitCount = 0; all read addresses = 0.
  - FSM returns to IDLE.
- Handshake: a query is accepted on a clock edge where queryValid && queryReady. querySSID is registered on that edge.
- States:
  - IDLE: queryReady = !storageBusy. On accept, drive rowIndex_HNM = SSID[SSIDBITS-1:COLINDEXBITS_HNM] and go to WAIT_HNM.
  - WAIT_HNM: count RD_LAT cycles, then sample bit = dataOutput_HNM[SSID[COLINDEXBITS_HNM-1:0]].
    - bit=0: pulse emptyDone, hitCount=0, return to IDLE.
    - bit=1: drive rowIndex_HCM = SSID and go to WAIT_HCM.
  - WAIT_HCM: after RD_LAT cycles, latch cnt = low MAXHITNBITS bits and addr = upper ROWINDEXBITS_HIM bits.
    - cnt=0 (corrupt entry): treat as empty and pulse emptyDone.
    - Otherwise set hitCount = cnt and overflow = (cnt > HITSPERROW), drive rowIndex_HIM = addr, go to WAIT_HIM.
  - WAIT_HIM: after RD_LAT cycles, latch the whole HIM row into a local register. Set n = min(cnt, HITSPERROW), slot = n-1, go to STREAM.
  - STREAM:
    - hitInfo = row[slot*HITINFOBITS +: HITINFOBITS]; hitValid=1; hitLast = (slot==0).
    - On hitValid && hitReady: if slot==0 go to IDLE, else slot decrements.
    - Hits are emitted oldest first; storage shifts older hits to higher slots.
- Output stability: hitInfo and hitLast are held while hitValid && !hitReady.
- Latencies: found path gives the first beat 3*RD_LAT+1 cycles after accept; empty path gives emptyDone RD_LAT+1 cycles after accept.
- Back-to-back: the next query can be accepted on the cycle after the last beat transfers or after emptyDone.
- storageBusy rising mid-query: ignored. The result reflects memory content at read time, and keeping queries and writes exclusive is the system's job.
- Reset asserted mid-query: abort immediately, drop any partial stream (no hitLast), restore reset values.
- Read addresses: hold their last value when not in use. The block never writes memory.

Decomposition:
- Shared package holds:
  - SSIDBITS, COLINDEXBITS_HNM, ROWINDEXBITS_HIM, MAXHITNBITS, HITINFOBITS, HITSPERROW.
  - Derived NCOLS_HNM, NCOLS_HCM, NCOLS_HIM.
  - FSM state encoding.
  - HCM field-extract helper functions shared with the storage stage.
- One sub-module: mem_read_waiter, a RD_LAT down-counter with start/done strobes, instanced once and reused by the three WAIT states.

Test Plan:
1. HNM row 0x05 bit 3 = 0; query SSID 0x00A3 -> rowIndex_HNM=0x05, emptyDone pulse 2 cycles after accept (RD_LAT=1), no hitValid.
2. SSID 0x0042: HNM bit set, HCM = {addr 0x011, cnt 2}, HIM[0x011] = {0x00,0xBB,0xAA} -> hitCount=2, beats 0xBB then 0xAA (hitLast on 0xAA), first beat 4 cycles after accept.
3. Same as 2 with hitReady held low for 5 cycles -> hitInfo=0xBB stays stable, no beat lost or duplicated.
4. HCM cnt=5, HIM = {0x33,0x22,0x11} -> overflow=1, hitCount=5, exactly 3 beats 0x33, 0x22, 0x11.
5. storageBusy=1 with queryValid=1 -> queryReady=0, no read address change; storageBusy drops -> accept next cycle.
6. Reset asserted during STREAM after the first beat -> hitValid=0 next cycle, no hitLast; a fresh query after reset completes correctly.
